// File: rtl/i2c_seq_pkg.sv
// i2c_seq_pkg: shared state encoding and response error codes for the I2C register sequencer
package i2c_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR_GO,
        ADDR_WAIT,
        DATA_GO,
        DATA_WAIT,
        RESP
    } state_t;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_MASTER  = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

endpackage

// File: rtl/i2c_seq_timeout.sv
// i2c_seq_timeout: saturating wait counter; expired once LIMIT-1 cycles have been counted since the last clear
module i2c_seq_timeout #(
    parameter int LIMIT = 65535
) (
    input  logic i_Clk,
    input  logic i_Rst_n,
    input  logic i_Clr,
    input  logic i_En,
    output logic o_Expired
);

    localparam int TW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [TW-1:0] r_Count;

    // Count enabled cycles, holding at the limit instead of wrapping
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n || i_Clr)
            r_Count <= '0;
        else if (i_En && r_Count != TW'(LIMIT - 1))
            r_Count <= r_Count + 1'b1;
    end

    assign o_Expired = r_Count == TW'(LIMIT - 1);

endmodule

// File: rtl/i2c_reg_sequencer.sv
// i2c_reg_sequencer: splits register read/write requests into address and data byte transactions
// for the single-byte I2C master; optional retry on master error with I2C_REG_SEQ_RETRY_EN.
module i2c_reg_sequencer
    import i2c_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 65535
`ifdef I2C_REG_SEQ_RETRY_EN
    , parameter int MAX_RETRIES = 2
`endif
) (
    input  logic       i_Clk,
    input  logic       i_Rst_n,
    input  logic       i_Req_Valid,
    output logic       o_Req_Ready,
    input  logic       i_Req_Rd,
    input  logic [7:0] i_Req_Reg,
    input  logic [7:0] i_Req_Data,
    output logic       o_Rsp_Valid,
    output logic [7:0] o_Rsp_Data,
    output logic [1:0] o_Rsp_Err,
    output logic       o_Wr_Start,
    output logic       o_Rd_Start,
    output logic [7:0] o_Wr_Byte,
    input  logic       i_Busy,
    input  logic [7:0] i_Rd_Byte,
    input  logic       i_Error
);

    state_t     r_State;
    logic       r_Rd;
    logic [7:0] r_Reg;
    logic [7:0] r_Data;
    logic       r_Seen;
    logic       w_Wait;
    logic       w_Done;
    logic       w_Expired;
    logic       w_Retry;

    assign w_Wait = (r_State == ADDR_WAIT) || (r_State == DATA_WAIT);
    assign w_Done = r_Seen && !i_Busy;

    i2c_seq_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .i_Clk     (i_Clk),
        .i_Rst_n   (i_Rst_n),
        .i_Clr     ((r_State == ADDR_GO) || (r_State == DATA_GO)),
        .i_En      (w_Wait),
        .o_Expired (w_Expired)
    );

`ifdef I2C_REG_SEQ_RETRY_EN
    localparam int RW = ($clog2(MAX_RETRIES + 1) > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    logic [RW-1:0] r_Retry;

    assign w_Retry = r_Retry < RW'(MAX_RETRIES);

    // Count restarts of the current request; cleared whenever idle
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n || r_State == IDLE)
            r_Retry <= '0;
        else if (w_Wait && w_Done && i_Error && w_Retry)
            r_Retry <= r_Retry + 1'b1;
    end
`else
    assign w_Retry = 1'b0;
`endif

    // Request sequencing; start pulses and responses are raised on entry so they show in the GO/RESP cycle
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            r_State     <= IDLE;
            r_Rd        <= 1'b0;
            r_Reg       <= 8'h00;
            r_Data      <= 8'h00;
            r_Seen      <= 1'b0;
            o_Req_Ready <= 1'b0;
            o_Rsp_Valid <= 1'b0;
            o_Rsp_Data  <= 8'h00;
            o_Rsp_Err   <= ERR_OK;
            o_Wr_Start  <= 1'b0;
            o_Rd_Start  <= 1'b0;
            o_Wr_Byte   <= 8'h00;
        end else begin
            o_Wr_Start  <= 1'b0;
            o_Rd_Start  <= 1'b0;
            o_Rsp_Valid <= 1'b0;
            case (r_State)
                IDLE: begin
                    o_Req_Ready <= 1'b1;
                    if (i_Req_Valid && o_Req_Ready) begin
                        r_Rd        <= i_Req_Rd;
                        r_Reg       <= i_Req_Reg;
                        r_Data      <= i_Req_Data;
                        o_Req_Ready <= 1'b0;
                        o_Wr_Byte   <= i_Req_Reg;
                        o_Wr_Start  <= 1'b1;
                        r_State     <= ADDR_GO;
                    end
                end
                ADDR_GO, DATA_GO: begin
                    r_Seen  <= i_Busy;
                    r_State <= (r_State == ADDR_GO) ? ADDR_WAIT : DATA_WAIT;
                end
                ADDR_WAIT, DATA_WAIT: begin
                    if (i_Busy)
                        r_Seen <= 1'b1;
                    if (w_Done && i_Error && w_Retry) begin
                        o_Wr_Byte  <= r_Reg;
                        o_Wr_Start <= 1'b1;
                        r_State    <= ADDR_GO;
                    end else if (w_Done && !i_Error && r_State == ADDR_WAIT) begin
                        o_Wr_Byte  <= r_Rd ? o_Wr_Byte : r_Data;
                        o_Wr_Start <= !r_Rd;
                        o_Rd_Start <= r_Rd;
                        r_State    <= DATA_GO;
                    end else if (w_Done) begin
                        o_Rsp_Valid <= 1'b1;
                        o_Rsp_Err   <= i_Error ? ERR_MASTER : ERR_OK;
                        o_Rsp_Data  <= (r_State == DATA_WAIT && r_Rd) ? i_Rd_Byte : 8'h00;
                        r_State     <= RESP;
                    end else if (w_Expired) begin
                        o_Rsp_Valid <= 1'b1;
                        o_Rsp_Err   <= ERR_TIMEOUT;
                        o_Rsp_Data  <= 8'h00;
                        r_State     <= RESP;
                    end
                end
                RESP: begin
                    o_Req_Ready <= 1'b1;
                    r_State     <= IDLE;
                end
                default: r_State <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// tb_i2c_reg_sequencer: directed requests against a behavioural master/slave model with a response scoreboard
module tb_i2c_reg_sequencer;

    localparam int M_OK = 0, M_ERR_RD = 1, M_ERR_ALL = 2, M_NOBUSY = 3;

    typedef struct {
        logic [7:0] data;
        logic [1:0] err;
        int         wr;
        int         rd;
        logic [7:0] b0;
        logic [7:0] b1;
        int         lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_rd = 1'b0;
    logic [7:0] req_reg = 8'h00;
    logic [7:0] req_data = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic [1:0] rsp_err;
    logic       wr_start;
    logic       rd_start;
    logic [7:0] wr_byte;
    logic       busy = 1'b0;
    logic [7:0] rd_byte = 8'h00;
    logic       error = 1'b0;

    int n_total = 0;
    int n_bad = 0;
    int mode = M_OK;
    int cyc = 0;
    int wr_n = 0;
    int rd_n = 0;
    int t0 = 0;
    logic [7:0] bytes [2];
    exp_t sb [$];

    logic [7:0] mem [256];
    logic [7:0] m_addr = 8'h00;
    logic       m_phase = 1'b0;
    logic       m_rd = 1'b0;
    int         m_cnt = 0;

    i2c_reg_sequencer #(
        .TIMEOUT_CYCLES (16)
`ifdef I2C_REG_SEQ_RETRY_EN
        , .MAX_RETRIES  (2)
`endif
    ) dut (
        .i_Clk       (clk),
        .i_Rst_n     (rst_n),
        .i_Req_Valid (req_valid),
        .o_Req_Ready (req_ready),
        .i_Req_Rd    (req_rd),
        .i_Req_Reg   (req_reg),
        .i_Req_Data  (req_data),
        .o_Rsp_Valid (rsp_valid),
        .o_Rsp_Data  (rsp_data),
        .o_Rsp_Err   (rsp_err),
        .o_Wr_Start  (wr_start),
        .o_Rd_Start  (rd_start),
        .o_Wr_Byte   (wr_byte),
        .i_Busy      (busy),
        .i_Rd_Byte   (rd_byte),
        .i_Error     (error)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input int act, input int exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic exp_t mk(input logic [7:0] data, input logic [1:0] err, input int wr, input int rd,
                                input logic [7:0] b0, input logic [7:0] b1, input int lat);
        exp_t e;
        e.data = data; e.err = err; e.wr = wr; e.rd = rd; e.b0 = b0; e.b1 = b1; e.lat = lat;
        return e;
    endfunction

    // Behavioural master plus register slave: 5 busy cycles per byte, error/idle behaviour by mode
    always @(posedge clk) begin
        if (wr_start && mode != M_NOBUSY) begin
            busy  <= 1'b1;
            m_cnt <= 5;
            m_rd  <= 1'b0;
            if (!m_phase) begin
                m_addr  <= wr_byte;
                m_phase <= 1'b1;
            end else begin
                mem[m_addr] <= wr_byte;
                m_phase     <= 1'b0;
            end
        end else if (rd_start && mode != M_NOBUSY) begin
            busy    <= 1'b1;
            m_cnt   <= 5;
            m_rd    <= 1'b1;
            m_phase <= 1'b0;
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                busy  <= 1'b0;
                error <= (mode == M_ERR_ALL) || (mode == M_ERR_RD && m_rd);
                if (mode == M_ERR_ALL || (mode == M_ERR_RD && m_rd))
                    m_phase <= 1'b0;
                if (m_rd)
                    rd_byte <= mem[m_addr];
            end
        end
    end

    // Monitor: tallies start pulses per request and checks each response against the scoreboard
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!rst_n) begin
            wr_n = 0;
            rd_n = 0;
        end else begin
            if (wr_start) begin
                if (wr_n == 0) t0 = cyc;
                if (wr_n < 2) bytes[wr_n] = wr_byte;
                wr_n++;
            end
            if (rd_start) rd_n++;
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    n_total++;
                    n_bad++;
                    $display("FAIL unexpected_rsp: got data 0x%0h err %0d with nothing pending", rsp_data, rsp_err);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_data", rsp_data, e.data);
                    chk("rsp_err", rsp_err, e.err);
                    chk("wr_pulses", wr_n, e.wr);
                    chk("rd_pulses", rd_n, e.rd);
                    if (e.wr >= 1) chk("byte0", bytes[0], e.b0);
                    if (e.wr >= 2) chk("byte1", bytes[1], e.b1);
                    if (e.lat > 0) chk("latency", cyc - t0, e.lat);
                end
                wr_n = 0;
                rd_n = 0;
            end
        end
    end

    task automatic check_zero(input string tag, input logic ready_exp);
        chk({tag, "_ready"}, req_ready, ready_exp);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_data"}, rsp_data, 0);
        chk({tag, "_rsp_err"}, rsp_err, 0);
        chk({tag, "_wr_start"}, wr_start, 0);
        chk({tag, "_rd_start"}, rd_start, 0);
        chk({tag, "_wr_byte"}, wr_byte, 0);
    endtask

    task automatic send(input logic rd, input logic [7:0] r, input logic [7:0] d, input exp_t e,
                        input bit push, input bit hold);
        int n;
        req_valid = 1'b1;
        req_rd    = rd;
        req_reg   = r;
        req_data  = d;
        n = 0;
        while (!req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait_expired", n >= 300, 0);
        if (push) sb.push_back(e);
        @(negedge clk);
        chk("ready_drop", req_ready, 0);
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", sb.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        repeat (3) @(negedge clk);
        check_zero("reset", 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", req_ready, 1);

        send(1'b0, 8'h10, 8'hAC, mk(8'h00, 2'b00, 2, 0, 8'h10, 8'hAC, 14), 1'b1, 1'b0);
        drain();
        chk("slave_reg10", mem[8'h10], 8'hAC);
        send(1'b1, 8'h10, 8'h00, mk(8'hAC, 2'b00, 1, 1, 8'h10, 8'h00, 14), 1'b1, 1'b0);
        drain();

        mode = M_ERR_RD;
`ifdef I2C_REG_SEQ_RETRY_EN
        send(1'b1, 8'h10, 8'h00, mk(8'hAC, 2'b01, 3, 3, 8'h10, 8'h10, 0), 1'b1, 1'b0);
`else
        send(1'b1, 8'h10, 8'h00, mk(8'hAC, 2'b01, 1, 1, 8'h10, 8'h00, 14), 1'b1, 1'b0);
`endif
        drain();

        mode = M_ERR_ALL;
`ifdef I2C_REG_SEQ_RETRY_EN
        send(1'b0, 8'h30, 8'h11, mk(8'h00, 2'b01, 3, 0, 8'h30, 8'h30, 0), 1'b1, 1'b0);
`else
        send(1'b0, 8'h30, 8'h11, mk(8'h00, 2'b01, 1, 0, 8'h30, 8'h00, 7), 1'b1, 1'b0);
`endif
        drain();
        chk("slave_reg30", mem[8'h30], 8'h00);

        mode = M_NOBUSY;
        send(1'b0, 8'h40, 8'h22, mk(8'h00, 2'b10, 1, 0, 8'h40, 8'h00, 17), 1'b1, 1'b0);
        drain();

        mode = M_OK;
        send(1'b0, 8'h50, 8'h66, mk(8'h00, 2'b00, 0, 0, 8'h00, 8'h00, 0), 1'b0, 1'b0);
        n = 0;
        while (wr_n < 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("data_start_wait_expired", n >= 100, 0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_zero("midreset", 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_midreset", req_ready, 1);
        drain();
        send(1'b1, 8'h50, 8'h00, mk(8'h66, 2'b00, 1, 1, 8'h50, 8'h00, 14), 1'b1, 1'b0);
        drain();

        send(1'b0, 8'h60, 8'h77, mk(8'h00, 2'b00, 2, 0, 8'h60, 8'h77, 14), 1'b1, 1'b1);
        send(1'b1, 8'h60, 8'h00, mk(8'h77, 2'b00, 1, 1, 8'h60, 8'h00, 14), 1'b1, 1'b1);
        send(1'b1, 8'h10, 8'h00, mk(8'hAC, 2'b00, 1, 1, 8'h10, 8'h00, 14), 1'b1, 1'b0);
        drain();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, pending=%0d", sb.size());
        $fatal(1, "global timeout");
    end

endmodule
